// File: rtl/timer_pkg.sv
// Shared definitions for the arbitrated prescaled countdown timer:
// FSM state encodings, a constant clog2 and the clock-to-tick divider.

`ifndef TIMER_DIV
`define TIMER_DIV(clk_hz, tick_hz) ((clk_hz) / (tick_hz))
`endif

package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ceiling log2, usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request found scanning
// upward from rr_ptr, wrapping modulo N_REQ. Outputs one-hot and index forms.

module rr_arbiter
    import timer_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] win,
    output logic [IW-1:0]    win_idx
);

    // Rotate so that bit 0 of req_rot is the requester rr_ptr points at.
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IW:0]        sum;
    logic               found;

    assign req_dbl = {req, req};
    assign req_rot = N_REQ'(req_dbl >> rr_ptr);

    // Lowest set bit of the rotated vector, mapped back to an absolute index.
    always_comb begin
        found   = 1'b0;
        sum     = '0;
        win_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, rr_ptr} + (IW+1)'(k);
                if (sum >= (IW+1)'(N_REQ)) begin
                    sum = sum - (IW+1)'(N_REQ);
                end
                win_idx = sum[IW-1:0];
            end
        end
        win = found ? (N_REQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/shared_timer_arb.sv
// One prescaled countdown timer shared by N_REQ requesters. An idle timer is
// granted round-robin; the owner's delay (in ticks) counts down and the owner
// gets a one-cycle done pulse on expiry. Dropping req while owning aborts.

module shared_timer_arb
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int N_REQ   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] dly,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   tick
);

    localparam int DIV = `TIMER_DIV(CLK_HZ, TICK_HZ);
    localparam int PW  = clog2(DIV);
    localparam int IW  = clog2(N_REQ);

    // Reject parameter sets the timer cannot honour at elaboration time.
    generate
        if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
            $error("shared_timer_arb: CLK_HZ/TICK_HZ must be an integer >= 2");
        end
        if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
            $error("shared_timer_arb: N_REQ must be in 2..8");
        end
    endgenerate

    state_e             state_q;
    logic [PW-1:0]      presc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IW-1:0]      rr_ptr_q;
    logic [IW-1:0]      owner_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   done_q;
    logic               busy_q;

    logic [CNT_W-1:0]   dly_arr [N_REQ];
    logic [N_REQ-1:0]   win;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      rr_ptr_d;
    logic               req_own;
    logic               tick_w;

    // Split the flat delay bus into one slice per requester.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_dly
            assign dly_arr[gi] = dly[gi*CNT_W +: CNT_W];
        end
    endgenerate

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .win     (win),
        .win_idx (win_idx)
    );

    // Next search starts just past the winner.
    assign rr_ptr_d = (win_idx == IW'(N_REQ-1)) ? '0 : win_idx + IW'(1);
    assign req_own  = req[owner_q];

    // Tick fires on the last prescaler count of a live, unexpired run only.
    assign tick_w = (state_q == RUN) && req_own && (cnt_q != '0)
                    && (presc_q == PW'(DIV-1));

    // Arbitration, prescaler, countdown and owner outputs in one FSM.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q  <= RUN;
                        gnt_q    <= win;
                        busy_q   <= 1'b1;
                        owner_q  <= win_idx;
                        cnt_q    <= dly_arr[win_idx];
                        presc_q  <= '0;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                RUN: begin
                    if (!req_own) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= DONE;
                        gnt_q   <= '0;
                        done_q  <= gnt_q;
                    end else if (tick_w) begin
                        presc_q <= '0;
                        cnt_q   <= cnt_q - CNT_W'(1);
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = busy_q;
    assign tick = tick_w;

endmodule

// File: tb/tb_shared_timer_arb.sv
// Directed bench for shared_timer_arb with DIV=10, N_REQ=4, CNT_W=8.
// Outputs are sampled on the falling edge; a monitor logs grant, done and
// tick events against a posedge cycle counter for timing checks.

module tb_shared_timer_arb;

    logic        clk;
    logic        clr;
    logic [3:0]  req;
    logic [31:0] dly;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        tick;

    typedef struct {
        int         c;
        logic [3:0] v;
        logic [3:0] g;
    } ev_t;

    ev_t  gnt_evs[$];
    ev_t  done_evs[$];
    int   tick_evs[$];

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic       mon_en = 1'b0;
    logic [3:0] gnt_prev = 4'b0;

    shared_timer_arb #(
        .CLK_HZ  (10),
        .TICK_HZ (1),
        .N_REQ   (4),
        .CNT_W   (8)
    ) dut (
        .clk  (clk),
        .clr  (clr),
        .req  (req),
        .dly  (dly),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .tick (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Event log plus invariants that must hold every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (gnt != 4'b0 && gnt_prev == 4'b0) gnt_evs.push_back('{cyc, gnt, gnt});
            if (done != 4'b0) done_evs.push_back('{cyc, done, gnt});
            if (tick) tick_evs.push_back(cyc);
            chk("excl_gnt_done", {28'b0, gnt & done}, 32'd0);
            chk("tick_only_run", {31'b0, tick & ~(|gnt)}, 32'd0);
        end
        gnt_prev <= gnt;
    end

    task automatic clear_log();
        gnt_evs.delete();
        done_evs.delete();
        tick_evs.delete();
    endtask

    task automatic wait_gnt(input string tag);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (gnt == 4'b0 && c < 8);
        if (gnt == 4'b0) chk({tag, "_gnt_timeout"}, 32'd0, 32'd1);
    endtask

    // Hold req until ndone done pulses are seen, then drop all requests.
    task automatic run_until_done(input string tag, input int ndone, input int maxc);
        int seen;
        int c;
        seen = 0;
        c = 0;
        while (seen < ndone && c < maxc) begin
            @(negedge clk);
            c++;
            if (done != 4'b0) seen++;
        end
        req = 4'b0;
        chk({tag, "_done_seen"}, seen, ndone);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        logic [3:0] order [5];
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        // 1: reset held with all requests high
        clr = 1'b1;
        req = 4'hF;
        dly = 32'h0;
        repeat (3) begin
            @(negedge clk);
            mon_en = 1'b1;
            chk("rst_outputs", {25'b0, gnt, done, busy, tick}, 32'd0);
        end
        clr = 1'b0;
        clear_log();
        wait_gnt("rst");
        chk("rst_first_gnt", gnt, 4'b0001);
        chk("rst_busy", busy, 1'b1);
        req = 4'b0;
        repeat (3) @(negedge clk);
        chk("rst_abort_nodone", done_evs.size(), 0);

        // 2: single request, dly=3 -> ticks at G+9/19/29, done at G+31
        clear_log();
        dly = 32'h0;
        dly[15:8] = 8'd3;
        req = 4'b0010;
        run_until_done("t2", 1, 60);
        chk("t2_ngnt", gnt_evs.size(), 1);
        chk("t2_nticks", tick_evs.size(), 3);
        chk("t2_ndone", done_evs.size(), 1);
        if (gnt_evs.size() > 0) begin
            g = gnt_evs[0].c;
            chk("t2_gnt", gnt_evs[0].v, 4'b0010);
            for (int i = 0; i < tick_evs.size() && i < 3; i++)
                chk("t2_tick_at", tick_evs[i] - g, 9 + 10 * i);
            if (done_evs.size() > 0) begin
                chk("t2_done_at", done_evs[0].c - g, 31);
                chk("t2_done_val", done_evs[0].v, 4'b0010);
                chk("t2_gnt_at_done", done_evs[0].g, 4'b0000);
            end
        end

        // 3: zero delay -> done at G+1, no tick
        clear_log();
        dly = 32'h0;
        req = 4'b0001;
        run_until_done("t3", 1, 20);
        chk("t3_nticks", tick_evs.size(), 0);
        if (gnt_evs.size() > 0 && done_evs.size() > 0) begin
            chk("t3_gnt", gnt_evs[0].v, 4'b0001);
            chk("t3_done_at", done_evs[0].c - gnt_evs[0].c, 1);
            chk("t3_done_val", done_evs[0].v, 4'b0001);
        end else begin
            chk("t3_events", gnt_evs.size() + done_evs.size(), 2);
        end

        // 4: round robin from rr_ptr=0, all dly=1.
        // Run G..G+10, DONE at G+11, IDLE G+12, next grant G+13 -> dones 13 apart.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        clear_log();
        dly = 32'h01010101;
        req = 4'hF;
        run_until_done("t4", 5, 120);
        chk("t4_ngnt", gnt_evs.size(), 5);
        chk("t4_ndone", done_evs.size(), 5);
        chk("t4_nticks", tick_evs.size(), 5);
        for (int i = 0; i < 5 && i < gnt_evs.size(); i++) begin
            chk("t4_order", gnt_evs[i].v, order[i]);
            if (i < done_evs.size()) begin
                chk("t4_done_lat", done_evs[i].c - gnt_evs[i].c, 11);
                chk("t4_done_owner", done_evs[i].v, gnt_evs[i].v);
                if (i > 0) chk("t4_done_gap", done_evs[i].c - done_evs[i-1].c, 13);
            end
        end

        // 5: abort of req2 at G+20, pending req3 granted at G+22
        clear_log();
        dly = 32'h0;
        dly[23:16] = 8'd5;
        dly[31:24] = 8'd2;
        req = 4'b1100;
        wait_gnt("t5");
        chk("t5_gnt", gnt, 4'b0100);
        repeat (20) @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        chk("t5_abort_gnt", gnt, 4'b0000);
        chk("t5_abort_busy", busy, 1'b0);
        chk("t5_abort_done", done, 4'b0000);
        @(negedge clk);
        chk("t5_next_gnt", gnt, 4'b1000);
        run_until_done("t5", 1, 40);
        chk("t5_ndone", done_evs.size(), 1);
        if (done_evs.size() > 0) chk("t5_done_val", done_evs[0].v, 4'b1000);

        // 6: reset mid-run clears outputs and rr_ptr
        clear_log();
        dly = 32'h0;
        dly[15:8] = 8'd4;
        req = 4'b0010;
        wait_gnt("t6");
        chk("t6_gnt", gnt, 4'b0010);
        repeat (15) @(negedge clk);
        clr = 1'b1;
        req = 4'b0011;
        @(negedge clk);
        chk("t6_rst_outputs", {25'b0, gnt, done, busy, tick}, 32'd0);
        clr = 1'b0;
        wait_gnt("t6_after");
        chk("t6_first_gnt", gnt, 4'b0001);
        req = 4'b0;
        repeat (4) @(negedge clk);
        chk("t6_nodone", done_evs.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
